// File: rtl/norm_shift_ctrl.sv
// Normalization control ahead of the FloatMul left barrel shifter: leading-zero count,
// exponent-clamped shift select, 2-stage valid/ready pipe. Optional macro NORM_UFLOW_CNT_EN.
module norm_shift_ctrl #(
  parameter int MW = 11,
  parameter int EW = 5,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] in_mant,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_mant,
  output logic [SW-1:0] out_sel,
  output logic [EW-1:0] out_exp,
  output logic          out_zero,
  output logic          out_uflow
`ifdef NORM_UFLOW_CNT_EN
  ,
  output logic [15:0]   uflow_cnt
`endif
);

  localparam int LZW = $clog2(MW + 1);
  localparam int CW  = (LZW > EW) ? LZW : EW;

  logic          s1_valid;
  logic [MW-1:0] s1_mant;
  logic [EW-1:0] s1_exp;
  logic          s1_adv;
  logic          s2_adv;

  logic [LZW-1:0] lzc;
  logic [CW-1:0]  lzc_w;
  logic [CW-1:0]  exp_w;
  logic [SW-1:0]  sel_d;
  logic [EW-1:0]  exp_d;
  logic           zero_d;
  logic           uflow_d;

  // Ready depends only on pipeline occupancy and out_ready, never on in_valid.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Higher bit positions overwrite lower ones, so the most significant set bit wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lzc = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (s1_mant[i]) lzc = LZW'(MW - 1 - i);
    end
  end

  always_comb begin
    lzc_w   = CW'(lzc);
    exp_w   = CW'(s1_exp);
    sel_d   = '0;
    exp_d   = '0;
    zero_d  = 1'b0;
    uflow_d = 1'b0;
    if (s1_mant == '0) begin
      zero_d = 1'b1;
    end else if (lzc_w <= exp_w) begin
      sel_d = SW'(lzc);
      exp_d = s1_exp - EW'(lzc);
    end else begin
      // Exponent would go negative: shift only as far as the exponent allows.
      sel_d   = SW'(s1_exp);
      uflow_d = 1'b1;
    end
  end

  // NOTE: datapath registers are reset as well, because the outputs must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all sequential state so stages update together.
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant <= in_mant;
        s1_exp  <= in_exp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_sel   <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mant  <= s1_mant;
        out_sel   <= sel_d;
        out_exp   <= exp_d;
        out_zero  <= zero_d;
        out_uflow <= uflow_d;
      end
    end
  end

`ifdef NORM_UFLOW_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uflow_cnt <= '0;
    end else if (out_valid && out_ready && out_uflow && (uflow_cnt != 16'hFFFF)) begin
      uflow_cnt <= uflow_cnt + 16'd1;
    end
  end
`endif

endmodule
